// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between a set of requesters and rr_grant_arbiter.
//   req       requester -> arbiter  request vector, bit i held while i wants the resource
//   done      requester -> arbiter  bit i pulses on requester i's last cycle of use
//   gnt       arbiter -> requester  registered one-hot (or zero) grant
//   gnt_valid arbiter -> requester  |gnt
//   gnt_idx   arbiter -> requester  binary index of the owner, 0 when no grant
//   timeout   arbiter -> requester  one-cycle pulse when a grant is forcibly revoked
interface rr_grant_arbiter_if #(
   parameter int unsigned NUM_REQ = 16,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] gnt;
   logic               gnt_valid;
   logic [IDX_W-1:0]   gnt_idx;
   logic               timeout;

   // Requester side.
   modport master (
      output req, done,
      input  gnt, gnt_valid, gnt_idx, timeout
   );

   // Arbiter side.
   modport slave (
      input  req, done,
      output gnt, gnt_valid, gnt_idx, timeout
   );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant, per-owner hold until done/req drop,
// a mandatory one-cycle idle turnaround between grants and an optional hold-time limit.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of rr_grant_arbiter_if (req/done in, gnt/gnt_valid/gnt_idx/timeout out)
module rr_grant_arbiter #(
   parameter int unsigned NUM_REQ  = 16,
   parameter int unsigned MAX_HOLD = 0,
   parameter int unsigned IDX_W    = $clog2(NUM_REQ),
   parameter int unsigned HOLD_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
   input logic              clk,
   input logic              rst,
   rr_grant_arbiter_if.slave bus
);

   localparam int unsigned HoldLast = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [HOLD_W-1:0]  hcnt_q, hcnt_d;
   logic               timeout_q, timeout_d;

   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic               own_done, own_req, limit_hit;

   // First requester at or above ptr, wrapping. Candidates stay below NUM_REQ, so a
   // non-power-of-two size never yields an out-of-range index.
   always_comb begin
      int unsigned        cand;
      logic [NUM_REQ-1:0] req_sh;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      req_sh    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(ptr_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         req_sh = bus.req >> cand;
         if (!win_found && req_sh[0]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   assign own_done  = bus.done[idx_q];
   assign own_req   = bus.req[idx_q];
   assign limit_hit = (MAX_HOLD != 0) && (hcnt_q == HOLD_W'(HoldLast));

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      hcnt_d    = hcnt_q;
      timeout_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               state_d = StGrant;
               gnt_d   = NUM_REQ'(1) << win_idx;
               idx_d   = win_idx;
               hcnt_d  = '0;
            end
         end
         StGrant: begin
            if (own_done || !own_req || limit_hit) begin
               state_d = StIdle;
               gnt_d   = '0;
               idx_d   = '0;
               ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
               // A cooperative release in the same cycle as the limit is not a timeout.
               timeout_d = limit_hit && !own_done && own_req;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         gnt_q     <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         hcnt_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         hcnt_q    <= hcnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = |gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Drives three arbiter instances (16/no limit, 16/limit 4, 5/limit 3) with shared stimulus
// and compares each against a queue-free behavioural model of owner, pointer and hold count.
module tb_rr_grant_arbiter;

   logic        clk;
   logic        rst;
   logic [15:0] req_v;
   logic [15:0] done_v;

   rr_grant_arbiter_if #(.NUM_REQ(16)) bus0 ();
   rr_grant_arbiter_if #(.NUM_REQ(16)) bus1 ();
   rr_grant_arbiter_if #(.NUM_REQ(5))  bus2 ();

   assign bus0.req  = req_v;
   assign bus0.done = done_v;
   assign bus1.req  = req_v;
   assign bus1.done = done_v;
   assign bus2.req  = req_v[4:0];
   assign bus2.done = done_v[4:0];

   rr_grant_arbiter #(.NUM_REQ(16), .MAX_HOLD(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   rr_grant_arbiter #(.NUM_REQ(16), .MAX_HOLD(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   rr_grant_arbiter #(.NUM_REQ(5),  .MAX_HOLD(3)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

   logic [15:0] o_gnt   [3];
   logic        o_valid [3];
   logic [3:0]  o_idx   [3];
   logic        o_to    [3];

   assign o_gnt[0]   = bus0.gnt;
   assign o_gnt[1]   = bus1.gnt;
   assign o_gnt[2]   = {11'd0, bus2.gnt};
   assign o_valid[0] = bus0.gnt_valid;
   assign o_valid[1] = bus1.gnt_valid;
   assign o_valid[2] = bus2.gnt_valid;
   assign o_idx[0]   = bus0.gnt_idx;
   assign o_idx[1]   = bus1.gnt_idx;
   assign o_idx[2]   = {1'b0, bus2.gnt_idx};
   assign o_to[0]    = bus0.timeout;
   assign o_to[1]    = bus1.timeout;
   assign o_to[2]    = bus2.timeout;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: owner (-1 = none), next-priority pointer, grant cycles held so far.
   int m_n     [3] = '{16, 16, 5};
   int m_hold  [3] = '{0, 4, 3};
   int m_owner [3];
   int m_ptr   [3];
   int m_cnt   [3];
   bit m_to    [3];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit bit_of(input logic [15:0] v, input int i);
      logic [15:0] s;
      s = v >> i;
      return s[0];
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_owner[d] = -1;
         m_ptr[d]   = 0;
         m_cnt[d]   = 0;
         m_to[d]    = 1'b0;
      end
   endtask

   // Applies one rising edge worth of arbitration rules to every model instance.
   task automatic model_update();
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            m_owner[d] = -1;
            m_ptr[d]   = 0;
            m_cnt[d]   = 0;
            m_to[d]    = 1'b0;
         end else if (m_owner[d] < 0) begin
            m_to[d] = 1'b0;
            for (int k = 0; k < m_n[d]; k++) begin
               int i;
               i = (m_ptr[d] + k) % m_n[d];
               if (m_owner[d] < 0 && bit_of(req_v, i)) begin
                  m_owner[d] = i;
                  m_cnt[d]   = 1;
               end
            end
         end else begin
            int o;
            bit dn, rq, lim;
            o   = m_owner[d];
            dn  = bit_of(done_v, o);
            rq  = bit_of(req_v, o);
            lim = (m_hold[d] != 0) && (m_cnt[d] == m_hold[d]);
            if (dn || !rq || lim) begin
               m_to[d]    = lim && !dn && rq;
               m_owner[d] = -1;
               m_ptr[d]   = (o + 1) % m_n[d];
            end else begin
               m_cnt[d] = m_cnt[d] + 1;
               m_to[d]  = 1'b0;
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int d = 0; d < 3; d++) begin
         logic [15:0] exp_gnt;
         int          set_idx;
         exp_gnt = (m_owner[d] < 0) ? 16'd0 : (16'd1 << m_owner[d]);
         check_eq($sformatf("d%0d gnt", d), 32'(o_gnt[d]), 32'(exp_gnt));
         check_eq($sformatf("d%0d gnt_valid", d), 32'(o_valid[d]), 32'(m_owner[d] >= 0));
         check_eq($sformatf("d%0d gnt_idx", d), 32'(o_idx[d]),
                  (m_owner[d] < 0) ? 32'd0 : 32'(m_owner[d]));
         check_eq($sformatf("d%0d timeout", d), 32'(o_to[d]), 32'(m_to[d]));
         // Structural invariants of the outputs themselves.
         check_eq($sformatf("d%0d onehot0", d), 32'($onehot0(o_gnt[d])), 32'd1);
         check_eq($sformatf("d%0d valid_or", d), 32'(o_valid[d]), 32'(|o_gnt[d]));
         set_idx = 0;
         for (int i = 0; i < 16; i++) if (bit_of(o_gnt[d], i)) set_idx = i;
         check_eq($sformatf("d%0d idx_match", d), 32'(o_idx[d]), 32'(set_idx));
      end
   endtask

   // Inputs are set after a falling edge; one call covers one rising edge.
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      rst    = 1'b1;
      req_v  = '0;
      done_v = '0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      rst = 1'b0;

      // Reset mid-grant clears the grant without a clock edge.
      req_v = 16'h0001;
      step();
      step();
      check_eq("pre_rst_gnt", 32'(o_gnt[0]), 32'h0001);
      #2 rst = 1'b1;
      #1 check_eq("rst_async_gnt", 32'(o_gnt[0]), 32'h0);
      check_eq("rst_async_valid", 32'(o_valid[0]), 32'h0);
      model_reset();
      compare_all();
      @(negedge clk);
      compare_all();
      rst   = 1'b0;
      req_v = 16'h8000;
      step();
      check_eq("post_rst_gnt", 32'(o_gnt[0]), 32'h8000);
      req_v = '0;
      step();

      // Rotation with every requester active, one-cycle grants.
      req_v = 16'hFFFF;
      for (int g = 0; g <= 16; g++) begin
         step();
         check_eq("rot_idx", 32'(o_idx[0]), 32'(g % 16));
         check_eq("rot_valid", 32'(o_valid[0]), 32'd1);
         done_v = 16'd1 << (g % 16);
         step();
         check_eq("rot_gap", 32'(o_gnt[0]), 32'd0);
         done_v = '0;
      end

      // Wrap and skip: pointer left at 14, then requests on 0 and 5.
      req_v = 16'h2000;
      step();
      check_eq("wrap_own13", 32'(o_gnt[0]), 32'h2000);
      done_v = 16'h2000;
      step();
      done_v = '0;
      req_v  = 16'h0021;
      step();
      check_eq("wrap_first", 32'(o_gnt[0]), 32'h0001);
      done_v = 16'h0001;
      step();
      check_eq("wrap_gap", 32'(o_gnt[0]), 32'h0);
      done_v = '0;
      step();
      check_eq("wrap_second", 32'(o_gnt[0]), 32'h0020);
      done_v = 16'h0020;
      step();
      done_v = '0;
      req_v  = '0;
      step();

      // Timeout on the limit-4 instance.
      req_v = 16'h0004;
      for (int c = 0; c < 4; c++) begin
         step();
         check_eq("to_hold", 32'(o_gnt[1]), 32'h0004);
         check_eq("to_quiet", 32'(o_to[1]), 32'd0);
      end
      step();
      check_eq("to_drop", 32'(o_gnt[1]), 32'h0);
      check_eq("to_pulse", 32'(o_to[1]), 32'd1);
      step();
      check_eq("to_regrant", 32'(o_gnt[1]), 32'h0004);
      check_eq("to_idx", 32'(o_idx[1]), 32'd2);
      check_eq("to_pulse_end", 32'(o_to[1]), 32'd0);
      req_v = '0;
      step();
      step();

      // Done in the 4th cycle coincides with the limit: a normal release.
      req_v = 16'h0004;
      step();
      done_v = 16'h0008;
      step();
      check_eq("sim_nonowner", 32'(o_gnt[1]), 32'h0004);
      done_v = '0;
      step();
      step();
      check_eq("sim_c4", 32'(o_gnt[1]), 32'h0004);
      done_v = 16'h0004;
      step();
      check_eq("sim_drop", 32'(o_gnt[1]), 32'h0);
      check_eq("sim_no_to", 32'(o_to[1]), 32'd0);
      done_v = '0;
      req_v  = '0;
      step();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) req_v = 16'($urandom) & 16'($urandom);
         if ($urandom_range(0, 3) == 0) done_v = 16'($urandom) & 16'($urandom);
         else done_v = '0;
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Parameterized round-robin arbiter that shares one downstream resource among `NUM_REQ` requesters. It issues a registered one-hot grant, holds it for the owner's transaction, and rotates priority so every active requester is served within `NUM_REQ` grants. An optional hold-time limit forces release if an owner never signals completion. It sits in front of any shared datapath whose select input must be one-hot, so its grant vector can be checked directly by the one-hot checker.

## Interface
- `NUM_REQ`, 16: number of requesters, ≥2.
- `MAX_HOLD`, 0: maximum grant length in cycles. 0 disables the timeout.
- `IDX_W`, `$clog2(NUM_REQ)`: width of `gnt_idx`. Derived; do not override.
- `HOLD_W`, `$clog2(MAX_HOLD+1)` (minimum 1): width of the hold counter. Derived.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  request vector; bit i held high while requester i wants the resource.
- `done`  in  NUM_REQ  bit i pulses high on requester i's last cycle of use. Ignored unless i is the owner.
- `gnt`  out  NUM_REQ  registered grant. Always all-zero or exactly one bit set.
- `gnt_valid`  out  1  equals `|gnt`.
- `gnt_idx`  out  IDX_W  binary index of the owner. 0 when `gnt_valid`=0.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- State machine with two states:
  - IDLE: no grant.
  - GRANT: one owner holds the resource.
- Internal state:
  - Priority pointer `ptr` (IDX_W bits).
  - Hold counter `hcnt` (HOLD_W bits).
- IDLE:
  - If `req`≠0, the winner is the first set bit found scanning upward from `ptr`, wrapping from NUM_REQ-1 to 0.
  - On the clock edge: `gnt` gets the winner as one-hot, `gnt_idx` gets the winner index, `hcnt` is cleared to 0, and the state moves to GRANT.
  - If `req`=0, stay in IDLE with `gnt`=0.
- GRANT, with owner o:
  - The grant ends when any of these holds: `done[o]`=1; `req[o]`=0; or `MAX_HOLD`≠0 and `hcnt`=MAX_HOLD-1.
  - When it ends: clear `gnt` and `gnt_idx`, set `ptr` to (o+1) mod NUM_REQ, and return to IDLE.
  - Otherwise increment `hcnt`.
- `timeout` is set for exactly one cycle only when the grant ends solely by the hold limit. If `done[o]` or `req[o]` drop fall in the same cycle as the limit, the end is normal and `timeout`=0.
- Every grant is followed by exactly one IDLE turnaround cycle. Back-to-back grants are never adjacent, so the resource always sees a gap of one all-zero `gnt` cycle.
- `done` or `req` changes on non-owner bits never affect the current grant.
- Pointer wrap: an owner at NUM_REQ-1 sets `ptr` to 0.
- A non-power-of-two NUM_REQ must never produce an index ≥ NUM_REQ.

## Timing
- Reset values, applied asynchronously: `gnt`=0, `gnt_valid`=0, `gnt_idx`=0, `timeout`=0, `ptr`=0, `hcnt`=0, state IDLE.
- Reset asserted mid-grant clears `gnt` immediately, without waiting for a clock edge.
- Grant latency: a request sampled at edge t in IDLE shows on `gnt` after edge t. Combinational paths from `req` to `gnt` are forbidden.
- Hold length:
  - Normal end: the owner keeps the grant through the cycle in which `done` is sampled high, and the grant drops after that edge.
  - Timeout end: the grant lasts exactly MAX_HOLD cycles, and `timeout` is high in the first IDLE cycle.
- Fairness: with all requests held high continuously, the owners cycle ptr, ptr+1, … mod NUM_REQ. Each grant takes at least 2 cycles including turnaround.
- `gnt_valid` and `gnt_idx` are registered alongside `gnt` and always consistent with it.

## Test plan
- **Reset mid-grant.** NUM_REQ=16. Assert `req`=0x0001, let the grant reach GRANT, then assert `rst` between clock edges.
  - Required: `gnt` goes to 0x0000 immediately.
  - After releasing `rst` with `req`=0x8000, the grant is 0x8000 after one edge.
- **Rotation.** `req`=0xFFFF held continuously; each owner pulses `done` on its first grant cycle.
  - Required: `gnt_idx` sequence 0,1,2,…,15,0, with `gnt`=0 between every pair of grants.
- **Wrap and skip.** `ptr`=14 (set by a prior grant to 13), then `req`=0x0021.
  - Required: the grant goes to idx 0 (0x0001), then idx 5 (0x0020).
- **Timeout.** MAX_HOLD=4, `req`=0x0004 held, `done` never asserted.
  - Required: `gnt`=0x0004 for exactly 4 cycles, then 0.
  - Required: `timeout`=1 for exactly 1 cycle, then a re-grant to idx 2 after the turnaround.
- **Simultaneous release.** MAX_HOLD=4, with `done[o]` asserted in the 4th grant cycle.
  - Required: the grant ends with `timeout`=0.
  - Required: a `done` pulse on a non-owner bit has no effect on the grant.
- **Invariant check on every cycle of all tests.**
  - Required: `gnt` is one-hot or zero.
  - Required: `gnt_valid` equals `|gnt`.
  - Required: `gnt_idx` matches the set bit of `gnt`.
